// File: rtl/song_menu_input_pkg.sv
// song_menu_input_pkg: mode codes, menu states and the wrapping step helper.
package song_menu_input_pkg;
  localparam logic [2:0] MODE_OFF   = 3'd0;
  localparam logic [2:0] MODE_FREE  = 3'd1;
  localparam logic [2:0] MODE_AUTO  = 3'd2;
  localparam logic [2:0] MODE_LEARN = 3'd3;
  localparam int NUM_SONGS_DEF = 3;
  typedef enum logic [1:0] {
    MODE_SEL = 2'd0,
    SONG_SEL = 2'd1,
    PLAYING  = 2'd2,
    ST_BAD   = 2'd3
  } menu_state_t;
  function automatic logic [3:0] step(input logic [3:0] v, input logic inc, input logic [3:0] hi);
    return inc ? (v >= hi ? 4'd1 : v + 4'd1) : (v <= 4'd1 ? hi : v - 4'd1);
  endfunction
endpackage

// File: rtl/song_menu_input_btn_debounce.sv
// btn_debounce: two-flop synchronizer, stability counter and rising-edge press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int CNT_W = 21
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);
  logic [1:0] sync;
  logic [CNT_W-1:0] cnt;
  logic level_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
      level_q <= 1'b0;
      press <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      level_q <= level;
      press <= level & ~level_q;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/song_menu_input.sv
// song_menu_input: debounced buttons driving the mode/song menu state machine.
module song_menu_input
  import song_menu_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int NUM_SONGS = NUM_SONGS_DEF,
  parameter int CNT_W = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_ok,
  input  logic       btn_back,
  input  logic       btn_user,
  input  logic       play_done,
  output logic [2:0] mode,
  output logic [3:0] num,
  output logic       user,
  output logic       play_start,
  output logic [1:0] menu_state
);
  logic [4:0] raw, lvl, prs, p;
  logic b, o, u, d;
  logic [3:0] sel_mode;
  menu_state_t state;
  assign raw = {btn_user, btn_back, btn_ok, btn_down, btn_up};
  for (genvar i = 0; i < 5; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk(clk), .reset(reset), .raw(raw[i]), .level(lvl[i]), .press(prs[i])
    );
  end
  assign p = prs & lvl;
  // back > ok > up > down; losers in the same cycle are dropped
  assign b = p[3];
  assign o = p[2] & ~p[3];
  assign u = p[0] & ~p[3] & ~p[2];
  assign d = p[1] & ~p[3] & ~p[2] & ~p[0];
  assign menu_state = state;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MODE_SEL;
      sel_mode <= 4'd1;
      mode <= MODE_OFF;
      num <= 4'd1;
      user <= 1'b0;
      play_start <= 1'b0;
    end else begin
      play_start <= 1'b0;
      if (p[4] && (state == MODE_SEL || state == SONG_SEL)) user <= ~user;
      case (state)
        MODE_SEL:
          if (o) begin
            mode <= 3'(sel_mode);
            state <= SONG_SEL;
          end else if (u | d) sel_mode <= step(sel_mode, u, 4'd3);
        SONG_SEL:
          if (b) begin
            mode <= MODE_OFF;
            state <= MODE_SEL;
          end else if (o) begin
            play_start <= 1'b1;
            state <= PLAYING;
          end else if (u | d) num <= step(num, u, 4'(NUM_SONGS));
        PLAYING:
          if (b | play_done) state <= SONG_SEL;
        default: begin
          mode <= MODE_OFF;
          state <= MODE_SEL;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_song_menu_input.sv
// tb_song_menu_input: directed test-plan walk plus random buttons against a window-based model.
module tb_song_menu_input;
  localparam int D = 4;
  localparam int NS = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] btn = '0;
  logic play_done = 1'b0;
  logic [2:0] mode;
  logic [3:0] num;
  logic user, play_start;
  logic [1:0] menu_state;
  int n_tests = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  song_menu_input #(.DEBOUNCE_CYCLES(D), .NUM_SONGS(NS), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .btn_up(btn[0]), .btn_down(btn[1]), .btn_ok(btn[2]),
    .btn_back(btn[3]), .btn_user(btn[4]), .play_done(play_done), .mode(mode), .num(num),
    .user(user), .play_start(play_start), .menu_state(menu_state)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // reference: raw sample history per button, window rule for acceptance, integer menu model
  logic [7:0] m_hist[5];
  bit m_lvl[5], m_lvld[5], m_prs[5];
  int m_st, m_sel, m_mode, m_num, m_user, m_ps;
  always @(posedge clk) begin
    bit all_diff, b, o, u, d;
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        m_hist[i] = '0;
        m_lvl[i] = 0;
        m_lvld[i] = 0;
        m_prs[i] = 0;
      end
      m_st = 0; m_sel = 1; m_mode = 0; m_num = 1; m_user = 0; m_ps = 0;
    end else begin
      b = m_prs[3];
      o = m_prs[2] && !b;
      u = m_prs[0] && !b && !m_prs[2];
      d = m_prs[1] && !b && !m_prs[2] && !m_prs[0];
      m_ps = 0;
      if (m_prs[4] && m_st != 2) m_user = 1 - m_user;
      if (m_st == 0) begin
        if (o) begin m_mode = m_sel; m_st = 1; end
        else if (u) m_sel = m_sel % 3 + 1;
        else if (d) m_sel = (m_sel + 1) % 3 + 1;
      end else if (m_st == 1) begin
        if (b) begin m_mode = 0; m_st = 0; end
        else if (o) begin m_ps = 1; m_st = 2; end
        else if (u) m_num = m_num % NS + 1;
        else if (d) m_num = (m_num + NS - 2) % NS + 1;
      end else if (b || play_done) m_st = 1;
      for (int i = 0; i < 5; i++) begin
        m_prs[i] = m_lvl[i] && !m_lvld[i];
        m_lvld[i] = m_lvl[i];
        m_hist[i] = {m_hist[i][6:0], btn[i]};
        all_diff = 1;
        for (int k = 2; k <= D + 1; k++) if (m_hist[i][k] == m_lvl[i]) all_diff = 0;
        if (all_diff) m_lvl[i] = !m_lvl[i];
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      check("mode", int'(mode), m_mode);
      check("num", int'(num), m_num);
      check("user", int'(user), m_user);
      check("play_start", int'(play_start), m_ps);
      check("menu_state", int'(menu_state), m_st);
    end
  end
  task automatic push(input logic [4:0] v, input int hold);
    @(negedge clk) btn = v;
    repeat (hold) @(negedge clk);
    btn = '0;
    repeat (8) @(negedge clk);
  endtask
  initial begin
    int hold;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mode", int'(mode), 0);
    check("rst_num", int'(num), 1);
    check("rst_user", int'(user), 0);
    check("rst_state", int'(menu_state), 0);
    push(5'b00100, 2);
    check("glitch_state", int'(menu_state), 0);
    push(5'b00100, 10);
    check("ok_mode", int'(mode), 1);
    check("ok_state", int'(menu_state), 1);
    push(5'b00010, 10);
    check("down_wrap", int'(num), 3);
    push(5'b00001, 10);
    check("up_wrap", int'(num), 1);
    push(5'b00001, 10);
    check("up_num", int'(num), 2);
    push(5'b00100, 10);
    check("play_state", int'(menu_state), 2);
    push(5'b00001, 10);
    push(5'b00010, 10);
    push(5'b00100, 10);
    push(5'b10000, 10);
    check("play_num", int'(num), 2);
    check("play_user", int'(user), 0);
    check("play_mode", int'(mode), 1);
    @(negedge clk) play_done = 1'b1;
    @(negedge clk) play_done = 1'b0;
    @(negedge clk);
    check("done_state", int'(menu_state), 1);
    check("done_mode", int'(mode), 1);
    push(5'b01000, 10);
    check("back_state", int'(menu_state), 0);
    push(5'b00010, 10);
    push(5'b00100, 10);
    check("learn_mode", int'(mode), 3);
    push(5'b01001, 10);
    check("prio_state", int'(menu_state), 0);
    check("prio_mode", int'(mode), 0);
    check("prio_num", int'(num), 2);
    push(5'b10000, 10);
    push(5'b00100, 10);
    push(5'b00100, 10);
    check("pre_rst_state", int'(menu_state), 2);
    check("pre_rst_user", int'(user), 1);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check("mid_rst_mode", int'(mode), 0);
    check("mid_rst_num", int'(num), 1);
    check("mid_rst_user", int'(user), 0);
    check("mid_rst_state", int'(menu_state), 0);
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (hold == 0) begin
        btn = ($urandom % 3 == 0) ? 5'b0 : 5'(1 << $urandom_range(0, 4));
        if ($urandom % 6 == 0) btn = btn | 5'(1 << $urandom_range(0, 4));
        hold = $urandom_range(1, 10);
      end else hold--;
      play_done = ($urandom % 25 == 0);
      reset = ($urandom % 700 == 0);
    end
    @(negedge clk);
    btn = '0;
    play_done = 1'b0;
    reset = 1'b0;
    repeat (12) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
